da_test: RTL and testbench

- UART-to-DAC bridge.
- Receives 8N1 serial bytes on `rx` at a fixed baud rate and presents each valid byte on an 8-bit parallel DAC bus `dadata`.
- Generates a free-running DAC sample clock `daclk` with `dadata` aligned to it.
- Sits between a host serial link and an external 8-bit parallel DAC.

---
 rtl/da_test.sv | 216 +++++++++++++++++++++
 tb/tb_da_test.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/da_test.sv
// -----------------------------------------------------------------------------
// da_test: UART-to-DAC bridge.
//
// Receives 8N1 serial bytes on rx and presents each valid byte on the 8-bit
// parallel DAC bus dadata. A free-running DAC sample clock daclk is generated
// from clk. dadata only changes on the clk edge where daclk falls, so it is
// stable around every daclk rising edge, where the DAC latches it.
//
// Parameters:
//   CLK_FREQ   - system clock frequency in Hz
//   BAUD       - serial bit rate
//   DACLK_HALF - clk cycles per daclk half-period
//
// Ports:
//   clk    in   system clock, all logic on the rising edge
//   reset  in   synchronous, active-high reset
//   rx     in   asynchronous UART input, idle high, LSB first
//   daclk  out  DAC sample clock, clk / (2 * DACLK_HALF)
//   dadata out  registered DAC data word
// -----------------------------------------------------------------------------
module da_test #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DACLK_HALF = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       daclk,
    output logic [7:0] dadata
);

    localparam int unsigned BIT_PERIOD  = CLK_FREQ / BAUD;
    localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
    localparam logic [12:0] BitLast     = 13'(BIT_PERIOD - 1);
    localparam logic [12:0] HalfLast    = 13'(HALF_PERIOD - 1);

    localparam int unsigned DCNT_W = (DACLK_HALF > 1) ? $clog2(DACLK_HALF) : 1;
    localparam logic [DCNT_W-1:0] DcntLast = DCNT_W'(DACLK_HALF - 1);

    // Receiver states
    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StStop     = 3'd3;
    localparam logic [2:0] StWaitIdle = 3'd4;

    // -------------------------------------------------------------------------
    // rx synchronizer, preset to the idle level so reset never looks like a
    // start bit.
    // -------------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Receiver FSM
    // -------------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    logic [12:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_valid;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + 13'd1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;

        case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!rx_sync_q) begin
                    bit_d   = '0;
                    state_d = StStart;
                end
            end

            // Sample the middle of the start bit; a high level there is a glitch.
            StStart: begin
                if (baud_q == HalfLast) begin
                    baud_d  = '0;
                    state_d = rx_sync_q ? StIdle : StData;
                end
            end

            StData: begin
                if (baud_q == BitLast) begin
                    baud_d  = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        state_d = StStop;
                    end
                end
            end

            // Leave mid-stop-bit so a back-to-back start edge is not missed.
            StStop: begin
                if (baud_q == BitLast) begin
                    baud_d = '0;
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StWaitIdle;
                    end
                end
            end

            // Framing error: hold off until the line returns high.
            StWaitIdle: begin
                baud_d = '0;
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                baud_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // -------------------------------------------------------------------------
    // daclk generator, free-running from reset release
    // -------------------------------------------------------------------------
    logic [DCNT_W-1:0] dcnt_q;
    logic              daclk_q;
    logic              dcnt_wrap;
    logic              daclk_fall;

    always_comb begin
        dcnt_wrap  = (dcnt_q == DcntLast);
        daclk_fall = dcnt_wrap && daclk_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q  <= '0;
            daclk_q <= 1'b0;
        end else if (dcnt_wrap) begin
            dcnt_q  <= '0;
            daclk_q <= ~daclk_q;
        end else begin
            dcnt_q <= dcnt_q + DCNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Holding register and DAC output. A byte that arrives on the same edge
    // as a daclk fall goes straight through; a newer byte overwrites an
    // older one still pending.
    // -------------------------------------------------------------------------
    logic [7:0] hold_q, hold_d;
    logic       pending_q, pending_d;
    logic [7:0] dadata_q, dadata_d;

    always_comb begin
        hold_d    = hold_q;
        pending_d = pending_q;
        dadata_d  = dadata_q;

        if (byte_valid) begin
            hold_d    = shift_q;
            pending_d = 1'b1;
        end

        if (daclk_fall && pending_d) begin
            dadata_d  = hold_d;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            pending_q <= 1'b0;
            dadata_q  <= '0;
        end else begin
            hold_q    <= hold_d;
            pending_q <= pending_d;
            dadata_q  <= dadata_d;
        end
    end

    assign daclk  = daclk_q;
    assign dadata = dadata_q;

endmodule

// File: tb/tb_da_test.sv
// -----------------------------------------------------------------------------
// tb_da_test: self-checking bench for da_test, run at a short bit period.
// -----------------------------------------------------------------------------
module tb_da_test;

    localparam int unsigned CLK_FREQ   = 3200000;
    localparam int unsigned BAUD       = 100000;
    localparam int unsigned DACLK_HALF = 2;
    localparam int unsigned BIT_CYC    = CLK_FREQ / BAUD;   // 32 clk per bit

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       daclk;
    logic [7:0] dadata;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] model_dadata = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         gap;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    da_test #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .DACLK_HALF (DACLK_HALF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .daclk  (daclk),
        .dadata (dadata)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; good frames are pushed on the scoreboard and popped
    // late in the stop bit, after the DUT had time to update dadata.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [7:0] exp;
        if (stop_bit) exp_q.push_back(data);
        rx = 1'b0;
        wait_neg(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_neg(BIT_CYC);
        end
        rx = stop_bit;
        wait_neg(BIT_CYC - 4);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            model_dadata = exp;
            check8("frame_data", dadata, exp);
        end
        wait_neg(4);
    endtask

    // dadata may only change on the edge where daclk falls (reset excepted).
    logic       prev_daclk  = 1'b0;
    logic [7:0] prev_dadata = 8'h00;

    always @(posedge clk) begin
        #1;
        if (!reset && dadata !== prev_dadata) begin
            checks++;
            if (!(prev_daclk === 1'b1 && daclk === 1'b0)) begin
                failures++;
                $display("FAIL dadata_edge: dadata %h->%h with daclk %b->%b at %0t",
                         prev_dadata, dadata, prev_daclk, daclk, $time);
            end
        end
        prev_daclk  = daclk;
        prev_dadata = dadata;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, gap: 40, exp: 8'hA5};
        vecs[1] = '{data: 8'h3C, stop_bit: 1'b0, gap: 40, exp: 8'hA5};
        vecs[2] = '{data: 8'h5A, stop_bit: 1'b1, gap: 40, exp: 8'h5A};
        vecs[3] = '{data: 8'h00, stop_bit: 1'b1, gap: 0,  exp: 8'h00};
        vecs[4] = '{data: 8'hFF, stop_bit: 1'b1, gap: 40, exp: 8'hFF};
        vecs[5] = '{data: 8'h01, stop_bit: 1'b1, gap: 40, exp: 8'h01};

        // Reset held 5 cycles with rx idle
        reset = 1'b1;
        rx    = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check1("reset_daclk", daclk, 1'b0);
            check8("reset_dadata", dadata, 8'h00);
        end
        reset = 1'b0;

        // daclk toggles every DACLK_HALF clk cycles after release
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            check1("daclk_run", daclk, logic'((n / DACLK_HALF) % 2));
        end
        check8("idle_dadata", dadata, 8'h00);
        wait_neg(20);

        // Frame table: good, framing error, good, back-to-back pair, good
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].stop_bit);
            rx = 1'b1;
            wait_neg(vecs[v].gap);
            check8("vec_dadata", dadata, vecs[v].exp);
        end

        // Short low glitch: false start
        rx = 1'b0;
        wait_neg(8);
        rx = 1'b1;
        wait_neg(2 * BIT_CYC);
        check8("false_start", dadata, model_dadata);

        // 1000-cycle low: framing error, no output
        rx = 1'b0;
        wait_neg(1000);
        rx = 1'b1;
        wait_neg(2 * BIT_CYC);
        check8("line_low", dadata, model_dadata);

        // Receiver recovers afterwards
        send_frame(8'h42, 1'b1);
        rx = 1'b1;
        wait_neg(40);

        // Reset in the middle of the data bits of 0x77
        rx = 1'b0;
        wait_neg(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            rx = logic'((8'h77 >> i) & 8'h01);
            wait_neg(BIT_CYC);
        end
        reset = 1'b1;
        rx    = 1'b1;
        wait_neg(5);
        check8("midreset_dadata", dadata, 8'h00);
        check1("midreset_daclk", daclk, 1'b0);
        reset = 1'b0;
        model_dadata = 8'h00;
        exp_q.delete();
        wait_neg(2 * BIT_CYC);
        check8("post_reset_idle", dadata, 8'h00);

        send_frame(8'h81, 1'b1);
        rx = 1'b1;
        wait_neg(40);
        check8("final_dadata", dadata, 8'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
